// File: rtl/fc_stream_mac.sv
// rtl/fc_stream_mac.sv - streaming fully-connected layer, NUM_OUT parallel MACs, serialized output
// Optional build macro FC_STREAM_RELU_EN clamps negative results to zero before storage.
module fc_stream_mac #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int OUT_W   = 16,
    parameter int MAX_LEN = 1024,
    parameter int NUM_OUT = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [$clog2(MAX_LEN+1)-1:0]  len_cfg,
    input  logic [4:0]                    shift_cfg,
    input  logic [NUM_OUT*DATA_W-1:0]     bias_in,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [$clog2(MAX_LEN)-1:0]    w_addr,
    output logic                          w_rden,
    input  logic [NUM_OUT*DATA_W-1:0]     w_data,
    output logic [OUT_W-1:0]              m_data,
    output logic [$clog2(NUM_OUT)-1:0]    m_idx,
    output logic                          m_valid,
    output logic                          m_last,
    input  logic                          m_ready,
    output logic                          busy,
    output logic                          done
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int AW    = $clog2(MAX_LEN);
    localparam int IDX_W = $clog2(NUM_OUT);
    localparam int PRD_W = 2 * DATA_W;
    // Wide enough for the accumulator plus a rounding constant of up to 2^30.
    localparam int SUM_W = ((ACC_W > 32) ? ACC_W : 32) + 2;
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BIAS, S_OUTPUT} state_t;

    state_t                     r_state, w_next;
    logic [LEN_W-1:0]           r_len, r_cnt, w_len_clamped;
    logic [4:0]                 r_shift;
    logic [NUM_OUT*DATA_W-1:0]  r_bias;
    logic signed [DATA_W-1:0]   r_sample;
    logic                       r_mac_en;
    logic signed [ACC_W-1:0]    r_acc [NUM_OUT];
    logic signed [OUT_W-1:0]    r_res [NUM_OUT];
    logic signed [OUT_W-1:0]    w_res [NUM_OUT];
    logic signed [PRD_W-1:0]    w_prod [NUM_OUT];
    logic signed [SUM_W-1:0]    w_sum, w_shifted, w_round;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_done;
    logic                       w_start_ok, w_accept, w_xfer, w_last_xfer;

    assign w_len_clamped = (len_cfg > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_cfg;
    // A start coinciding with the done pulse is deliberately dropped.
    assign w_start_ok  = (r_state == S_IDLE) && start && !r_done;
    assign w_accept    = (r_state == S_ACCUM) && (r_cnt < r_len) && s_valid;
    assign w_xfer      = (r_state == S_OUTPUT) && m_ready;
    assign w_last_xfer = w_xfer && (r_idx == IDX_W'(NUM_OUT - 1));

    always_comb begin
        w_next  = r_state;
        s_ready = 1'b0;
        w_rden  = 1'b0;
        w_addr  = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        m_idx   = '0;
        busy    = (r_state != S_IDLE);
        done    = r_done;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next = (w_len_clamped == '0) ? S_BIAS : S_ACCUM;
            end
            S_ACCUM: begin
                s_ready = (r_cnt < r_len);
                if (w_accept) begin
                    w_rden = 1'b1;
                    w_addr = r_cnt[AW-1:0];
                end
                // The cycle spent here with cnt==len is the drain that completes the last MAC.
                if (r_cnt >= r_len) w_next = S_BIAS;
            end
            S_BIAS: w_next = S_OUTPUT;
            S_OUTPUT: begin
                m_valid = 1'b1;
                m_idx   = r_idx;
                m_data  = r_res[r_idx];
                m_last  = (r_idx == IDX_W'(NUM_OUT - 1));
                if (w_last_xfer) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sum     = '0;
        w_shifted = '0;
        w_round   = (r_shift == 5'd0) ? '0 : (SUM_W'(1) << (r_shift - 5'd1));
        for (int k = 0; k < NUM_OUT; k++) begin
            w_prod[k] = r_sample * $signed(w_data[k*DATA_W +: DATA_W]);
            w_sum     = SUM_W'(r_acc[k]) + SUM_W'($signed(r_bias[k*DATA_W +: DATA_W])) + w_round;
            w_shifted = w_sum >>> r_shift;
            if (w_shifted > SAT_MAX)      w_res[k] = SAT_MAX[OUT_W-1:0];
            else if (w_shifted < SAT_MIN) w_res[k] = SAT_MIN[OUT_W-1:0];
            else                          w_res[k] = w_shifted[OUT_W-1:0];
`ifdef FC_STREAM_RELU_EN
            if (w_res[k] < 0) w_res[k] = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_bias   <= '0;
            r_sample <= '0;
            r_mac_en <= 1'b0;
            r_idx    <= '0;
            r_done   <= 1'b0;
            for (int k = 0; k < NUM_OUT; k++) begin
                r_acc[k] <= '0;
                r_res[k] <= '0;
            end
        end else begin
            r_state  <= w_next;
            r_done   <= w_last_xfer;
            r_mac_en <= w_accept;
            if (w_accept) begin
                r_sample <= s_data;
                r_cnt    <= r_cnt + 1'b1;
            end
            if (r_mac_en) begin
                for (int k = 0; k < NUM_OUT; k++)
                    r_acc[k] <= r_acc[k] + ACC_W'(w_prod[k]);
            end
            if (w_start_ok) begin
                r_len   <= w_len_clamped;
                r_shift <= shift_cfg;
                r_bias  <= bias_in;
                r_cnt   <= '0;
                for (int k = 0; k < NUM_OUT; k++) r_acc[k] <= '0;
            end
            if (r_state == S_BIAS) begin
                r_idx <= '0;
                for (int k = 0; k < NUM_OUT; k++) r_res[k] <= w_res[k];
            end
            if (w_xfer) r_idx <= w_last_xfer ? '0 : r_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_fc_stream_mac.sv
// tb/tb_fc_stream_mac.sv - directed self-checking bench for fc_stream_mac
module tb_fc_stream_mac;
    localparam int DATA_W = 8, ACC_W = 24, OUT_W = 16, MAX_LEN = 1024, NUM_OUT = 10;
    localparam int LEN_W = $clog2(MAX_LEN + 1), AW = $clog2(MAX_LEN), IDX_W = $clog2(NUM_OUT);

    logic                         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [LEN_W-1:0]             len_cfg = '0;
    logic [4:0]                   shift_cfg = '0;
    logic [NUM_OUT*DATA_W-1:0]    bias_in = '0;
    logic [DATA_W-1:0]            s_data = '0;
    logic                         s_valid = 1'b0, s_ready, w_rden, m_valid, m_last, busy, done;
    logic                         m_ready = 1'b1;
    logic [AW-1:0]                w_addr;
    logic [NUM_OUT*DATA_W-1:0]    w_data = '0;
    logic [OUT_W-1:0]             m_data;
    logic [IDX_W-1:0]             m_idx;

    fc_stream_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .MAX_LEN(MAX_LEN), .NUM_OUT(NUM_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len_cfg(len_cfg), .shift_cfg(shift_cfg),
        .bias_in(bias_in), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .w_addr(w_addr), .w_rden(w_rden), .w_data(w_data), .m_data(m_data), .m_idx(m_idx),
        .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .busy(busy), .done(done));

    always #5 clk = ~clk;

    int cyc = 0, sready_cnt = 0, rden_cnt = 0;
    int wmode = 0;
    logic signed [DATA_W-1:0] wval = 8'sd1;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_ready) sready_cnt <= sready_cnt + 1;
        if (w_rden) rden_cnt <= rden_cnt + 1;
        if (w_rden)
            for (int k = 0; k < NUM_OUT; k++)
                w_data[k*DATA_W +: DATA_W] <= (wmode == 0) ? wval : DATA_W'(w_addr + 1);
    end

    int n_checks = 0, n_fail = 0;
    int samp [MAX_LEN];
    logic signed [OUT_W-1:0] got [NUM_OUT];
    int n_xfer, order_err, hold_err, last_cnt, last_idx, first_lat, start_cyc;
    logic done_now, busy_now;

    task automatic do_start(input int len, input int shift, input int bias_base, input int bias_step);
        for (int k = 0; k < NUM_OUT; k++) bias_in[k*DATA_W +: DATA_W] = DATA_W'(bias_base + k * bias_step);
        @(posedge clk); #1;
        len_cfg = LEN_W'(len); shift_cfg = 5'(shift); start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit stall, input int first);
        bit acc;
        int t;
        for (int i = 0; i < n; i++) begin
            s_data = DATA_W'(samp[first + i]); s_valid = 1'b1; t = 0;
            do begin
                acc = s_ready;
                @(posedge clk); #1; t++;
            end while (!acc && t < 50);
            if (!acc) begin
                n_checks++; n_fail++;
                $display("FAIL feed_timeout: sample %0d not accepted, required s_ready within 50 cycles", first + i);
            end
            if (stall) begin
                s_valid = 1'b0; @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic collect(input int stall_idx);
        int stall_left, t, h_idx;
        bit held;
        logic [OUT_W-1:0] h_data;
        n_xfer = 0; order_err = 0; hold_err = 0; last_cnt = 0; last_idx = -1; first_lat = -1;
        stall_left = (stall_idx >= 0) ? 3 : 0; held = 0; t = 0; h_idx = 0; h_data = '0;
        m_ready = 1'b1;
        while (n_xfer < NUM_OUT && t < 200) begin
            if (held && (!m_valid || int'(m_idx) != h_idx || m_data !== h_data)) hold_err++;
            if (m_valid) begin
                if (first_lat < 0) first_lat = cyc - start_cyc;
                if (int'(m_idx) == stall_idx && stall_left > 0) begin
                    m_ready = 1'b0; stall_left--; held = 1; h_idx = int'(m_idx); h_data = m_data;
                end else begin
                    m_ready = 1'b1; held = 0;
                    if (int'(m_idx) != n_xfer) order_err++;
                    got[n_xfer] = m_data;
                    if (m_last) begin last_cnt++; last_idx = n_xfer; end
                    n_xfer++;
                end
            end
            @(posedge clk); #1; t++;
        end
        m_ready = 1'b1;
        done_now = done; busy_now = busy;
        n_checks++;
        if (n_xfer !== NUM_OUT) begin
            n_fail++;
            $display("FAIL collect_count: got %0d transfers, required %0d", n_xfer, NUM_OUT);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({s_ready, w_rden, m_valid, m_last, busy, done} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b required 000000", {s_ready, w_rden, m_valid, m_last, busy, done});
        end
        n_checks++;
        if (m_data !== '0 || m_idx !== '0 || w_addr !== '0) begin
            n_fail++; $display("FAIL reset_buses: m_data=%0h m_idx=%0d w_addr=%0d required 0", m_data, m_idx, w_addr);
        end
    endtask

    task automatic test_basic();
        wmode = 0; wval = 8'sd1;
        for (int i = 0; i < 4; i++) samp[i] = i + 1;
        do_start(4, 0, 0, 1);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", busy); end
        feed(4, 0, 0);
        collect(-1);
        for (int k = 0; k < NUM_OUT; k++) begin
            n_checks++;
            if (got[k] !== OUT_W'(10 + k)) begin n_fail++; $display("FAIL basic_data[%0d]: got %0d required %0d", k, got[k], 10 + k); end
        end
        n_checks++;
        if (last_cnt != 1 || last_idx != 9) begin n_fail++; $display("FAIL basic_last: count %0d at idx %0d, required 1 at 9", last_cnt, last_idx); end
        n_checks++;
        if (first_lat != 7) begin n_fail++; $display("FAIL basic_latency: got %0d required 7", first_lat); end
        n_checks++;
        if (done_now !== 1'b1 || busy_now !== 1'b0) begin n_fail++; $display("FAIL basic_done: done=%b busy=%b required 1/0", done_now, busy_now); end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b required 0", done); end
    endtask

    task automatic test_backpressure();
        do_start(4, 0, 0, 1);
        feed(4, 1, 0);
        collect(4);
        for (int k = 0; k < NUM_OUT; k++) begin
            n_checks++;
            if (got[k] !== OUT_W'(10 + k)) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d required %0d", k, got[k], 10 + k); end
        end
        n_checks++;
        if (order_err != 0 || hold_err != 0) begin n_fail++; $display("FAIL bp_order_hold: order_err=%0d hold_err=%0d required 0/0", order_err, hold_err); end
        n_checks++;
        if (done_now !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b required 1", done_now); end
    endtask

    task automatic test_rounding();
        int exp_r [NUM_OUT] = '{3, 3, 3, 3, 4, 4, 4, 4, 5, 5};
        do_start(4, 2, 0, 1);
        feed(4, 0, 0);
        collect(-1);
        for (int k = 0; k < NUM_OUT; k++) begin
            n_checks++;
            if (got[k] !== OUT_W'(exp_r[k])) begin n_fail++; $display("FAIL round[%0d]: got %0d required %0d", k, got[k], exp_r[k]); end
        end
    endtask

    task automatic test_saturation();
        int wv [4] = '{127, 127, -127, -127};
        int sh [4] = '{2, 0, 0, 2};
`ifdef FC_STREAM_RELU_EN
        int ex [4] = '{32258, 32767, 0, 0};
`else
        int ex [4] = '{32258, 32767, -32768, -32258};
`endif
        for (int i = 0; i < 8; i++) samp[i] = 127;
        for (int c = 0; c < 4; c++) begin
            wval = DATA_W'(wv[c]);
            do_start(8, sh[c], 0, 0);
            feed(8, 0, 0);
            collect(-1);
            for (int k = 0; k < NUM_OUT; k += 3) begin
                n_checks++;
                if (got[k] !== OUT_W'(ex[c])) begin n_fail++; $display("FAIL sat_case%0d[%0d]: got %0d required %0d", c, k, got[k], ex[c]); end
            end
        end
        wval = 8'sd1;
    endtask

    task automatic test_zero_len();
`ifdef FC_STREAM_RELU_EN
        int ex = 0;
`else
        int ex = -3;
`endif
        int sr0, rd0;
        s_valid = 1'b1; s_data = 8'd9;
        sr0 = sready_cnt; rd0 = rden_cnt;
        do_start(0, 0, -3, 0);
        collect(-1);
        s_valid = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            n_checks++;
            if (got[k] !== OUT_W'(ex)) begin n_fail++; $display("FAIL zero_data[%0d]: got %0d required %0d", k, got[k], ex); end
        end
        n_checks++;
        if (sready_cnt != sr0 || rden_cnt != rd0) begin n_fail++; $display("FAIL zero_no_ready: s_ready %0d w_rden %0d cycles, required 0", sready_cnt - sr0, rden_cnt - rd0); end
        n_checks++;
        if (done_now !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b required 1", done_now); end
    endtask

    task automatic test_addr_weights();
        wmode = 1;
        samp[0] = 2; samp[1] = 3; samp[2] = 4;
        do_start(3, 0, 0, 0);
        feed(3, 1, 0);
        collect(-1);
        for (int k = 0; k < NUM_OUT; k += 4) begin
            n_checks++;
            if (got[k] !== OUT_W'(20)) begin n_fail++; $display("FAIL addr_w[%0d]: got %0d required 20", k, got[k]); end
        end
        wmode = 0;
    endtask

    task automatic test_clamp();
        for (int i = 0; i < MAX_LEN; i++) samp[i] = 1;
        do_start(1100, 0, 0, 0);
        feed(MAX_LEN, 0, 0);
        s_valid = 1'b1;
        n_checks++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL clamp_ready: got %b required 0", s_ready); end
        s_valid = 1'b0;
        collect(-1);
        n_checks++;
        if (got[0] !== OUT_W'(MAX_LEN) || got[9] !== OUT_W'(MAX_LEN)) begin
            n_fail++; $display("FAIL clamp_sum: got %0d/%0d required %0d", got[0], got[9], MAX_LEN);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) samp[i] = i + 1;
        do_start(4, 0, 0, 1);
        feed(2, 0, 0);
        rst_n = 1'b0; #1;
        n_checks++;
        if ({s_ready, w_rden, m_valid, m_last, busy, done} !== 6'b0 || m_data !== '0 || m_idx !== '0 || w_addr !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: flags=%b m_data=%0h m_idx=%0d w_addr=%0d required all 0",
                               {s_ready, w_rden, m_valid, m_last, busy, done}, m_data, m_idx, w_addr);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        samp[0] = 3; samp[1] = 4;
        do_start(2, 0, 0, 0);
        feed(1, 0, 0);
        len_cfg = LEN_W'(5); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed(1, 0, 1);
        collect(-1);
        for (int k = 0; k < NUM_OUT; k += 3) begin
            n_checks++;
            if (got[k] !== OUT_W'(7)) begin n_fail++; $display("FAIL midreset_rerun[%0d]: got %0d required 7", k, got[k]); end
        end
    endtask

    task automatic test_back_to_back();
        samp[0] = 5;
        do_start(1, 0, 0, 0);
        feed(1, 0, 0);
        collect(-1);
        n_checks++;
        if (got[3] !== OUT_W'(5)) begin n_fail++; $display("FAIL b2b_first: got %0d required 5", got[3]); end
        len_cfg = LEN_W'(1); start = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_at_done: busy=%b required 0", busy); end
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_start_after: busy=%b required 1", busy); end
        samp[0] = 6;
        feed(1, 0, 0);
        collect(-1);
        n_checks++;
        if (got[7] !== OUT_W'(6) || first_lat != 4) begin
            n_fail++; $display("FAIL b2b_second: data %0d latency %0d required 6 and 4", got[7], first_lat);
        end
    endtask

    initial begin
        #12;
        test_reset();
        @(posedge clk); #1; rst_n = 1'b1;
        test_basic();
        test_backpressure();
        test_rounding();
        test_saturation();
        test_zero_len();
        test_addr_weights();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
